// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int MAX_PORTS = 16;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xdata_t;

    // Number of set bits; used to count how many write ports release one register.
    function automatic int unsigned count_ones(input logic [MAX_PORTS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_pend_ctr.sv
// Pending-write counter for one architectural register: counts reservations
// minus releases, clears on flush, and clamps to zero on over-release.
module rf_pend_ctr #(
    parameter int PW = 2,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          inc,
    input  logic [DW-1:0] dec,
    output logic          nonzero,
    output logic          saturated,
    output logic          underflow
);

    localparam int SW = PW + DW + 1;

    logic [PW-1:0] r_count;
    logic [PW-1:0] r_count_next;
    logic [SW-1:0] w_avail;
    logic          w_under;

    assign w_avail   = SW'(r_count) + SW'(inc);
    assign w_under   = SW'(dec) > w_avail;
    // A flush discards releases, so they cannot signal an error either.
    assign underflow = w_under & ~flush;
    assign nonzero   = |r_count;
    assign saturated = &r_count;

    // Next count: flush or over-release clear, otherwise net reserve/release.
    always_comb begin
        r_count_next = PW'(w_avail - SW'(dec));
        if (flush || w_under) begin
            r_count_next = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= r_count_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass and a counting write scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 4,
    parameter int NWR   = 2,
    parameter int PW    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRD-1:0][$clog2(NREGS)-1:0] rd_addr,
    output logic [NRD-1:0][XLEN-1:0]  rd_data,
    input  logic [NWR-1:0]            wr_en,
    input  logic [NWR-1:0][$clog2(NREGS)-1:0] wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]  wr_data,
    input  logic [NWR-1:0]            wr_rel,
    input  logic                      rsv_valid,
    input  logic [$clog2(NREGS)-1:0]  rsv_addr,
    output logic                      rsv_ready,
    input  logic                      flush,
    output logic [NREGS-1:0]          pending,
    output logic                      sb_err
);

    localparam int AW = $clog2(NREGS);
    localparam int DW = $clog2(NWR + 1);

    // x0 has no storage; it always reads as zero.
    logic [XLEN-1:0]  r_mem [1:NREGS-1];
    logic             r_sb_err;
    logic [NREGS-1:0] w_nz;
    logic [NREGS-1:0] w_sat;
    logic [NREGS-1:0] w_uflow;
    logic             w_rsv_rel;

    assign w_nz[0]    = 1'b0;
    assign w_sat[0]   = 1'b0;
    assign w_uflow[0] = 1'b0;

    // Storage update: later (higher-index) ports overwrite earlier ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[p] != '0)) begin
                    r_mem[wr_addr[p]] <= wr_data[p];
                end
            end
        end
    end

    // Combinational read with same-cycle bypass, highest-index writer wins.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_addr[i] != '0) begin
                rd_data[i] = r_mem[rd_addr[i]];
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && (wr_addr[p] == rd_addr[i])) begin
                        rd_data[i] = wr_data[p];
                    end
                end
            end
        end
    end

    // A same-cycle release frees a slot, so a saturated register can still accept.
    always_comb begin
        w_rsv_rel = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_rel[p] && (wr_addr[p] == rsv_addr)) begin
                w_rsv_rel = 1'b1;
            end
        end
    end

    assign rsv_ready = ~w_sat[rsv_addr] | w_rsv_rel;
    assign pending   = w_nz;
    assign sb_err    = r_sb_err;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_ctr
            logic [NWR-1:0] w_hit;
            logic [DW-1:0]  w_dec;
            logic           w_inc;

            // Ports releasing this register this cycle (x0 never reaches here).
            always_comb begin
                w_hit = '0;
                for (int p = 0; p < NWR; p++) begin
                    w_hit[p] = wr_en[p] & wr_rel[p] & (wr_addr[p] == AW'(gi));
                end
            end

            assign w_dec = DW'(count_ones(MAX_PORTS'(w_hit)));
            assign w_inc = rsv_valid & rsv_ready & (rsv_addr == AW'(gi));

            rf_pend_ctr #(
                .PW (PW),
                .DW (DW)
            ) u_ctr (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .inc       (w_inc),
                .dec       (w_dec),
                .nonzero   (w_nz[gi]),
                .saturated (w_sat[gi]),
                .underflow (w_uflow[gi])
            );
        end
    endgenerate

    // Sticky scoreboard error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_err <= 1'b0;
        end else if (|w_uflow) begin
            r_sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// checked against a behavioural model of registers and per-register counts.
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int PW    = 2;
    localparam int AW    = 5;
    localparam int CMAX  = (1 << PW) - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][XLEN-1:0]  rd_data;
    logic [NWR-1:0]            wr_en;
    logic [NWR-1:0][AW-1:0]    wr_addr;
    logic [NWR-1:0][XLEN-1:0]  wr_data;
    logic [NWR-1:0]            wr_rel;
    logic                      rsv_valid;
    logic [AW-1:0]             rsv_addr;
    logic                      rsv_ready;
    logic                      flush;
    logic [NREGS-1:0]          pending;
    logic                      sb_err;

    // Behavioural model
    logic [XLEN-1:0] m_mem [NREGS];
    int              m_cnt [NREGS];
    bit              m_err;
    bit              chk_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .PW    (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_rel    (wr_rel),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .flush     (flush),
        .pending   (pending),
        .sb_err    (sb_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected read: zero for x0, else newest same-cycle writer, else stored value.
    function automatic logic [63:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return 64'd0;
        for (int p = NWR - 1; p >= 0; p--) begin
            if (wr_en[p] && wr_addr[p] == a) return wr_data[p];
        end
        return m_mem[a];
    endfunction

    function automatic bit m_ready();
        if (rsv_addr == 0) return 1'b1;
        if (m_cnt[rsv_addr] < CMAX) return 1'b1;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_rel[p] && wr_addr[p] == rsv_addr) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic idle();
        rst       = 1'b0;
        rd_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_rel    = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        flush     = 1'b0;
    endtask

    // Check outputs against the model, advance the model, clock once.
    // Called just after a falling edge with inputs already applied.
    task automatic run_cycle();
        logic [NREGS-1:0] exp_pend;
        bit               rdy;
        int               inc, dec;
        #1;
        rdy = m_ready();
        if (chk_en) begin
            for (int i = 0; i < NRD; i++) begin
                check($sformatf("rd%0d", i), rd_data[i], m_read(rd_addr[i]));
            end
            exp_pend = '0;
            for (int r = 1; r < NREGS; r++) exp_pend[r] = (m_cnt[r] != 0);
            check("pending", 64'(pending), 64'(exp_pend));
            check("rsv_ready", 64'(rsv_ready), 64'(rdy));
            check("sb_err", 64'(sb_err), 64'(m_err));
            $display("cyc t=%0t rst=%0b wr_en=%b rsv=%0b@%0d flush=%0b pend=%h err=%0b",
                     $time, rst, wr_en, rsv_valid, rsv_addr, flush, pending, sb_err);
        end
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r] = '0;
                m_cnt[r] = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                inc = (rsv_valid && rdy && rsv_addr == r) ? 1 : 0;
                dec = 0;
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && wr_rel[p] && wr_addr[p] == r) dec++;
                end
                if (flush) begin
                    m_cnt[r] = 0;
                end else if (dec > m_cnt[r] + inc) begin
                    m_cnt[r] = 0;
                    m_err    = 1'b1;
                end else begin
                    m_cnt[r] = m_cnt[r] + inc - dec;
                end
            end
            for (int r = 1; r < NREGS; r++) m_mem[r] = m_read(AW'(r));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst    = 1'b1;
        chk_en = 1'b0;
        @(negedge clk);
        run_cycle();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        rd_addr = {5'd0, 5'd31, 5'd5, 5'd0};
        #1;
        check("rst_rd_x5", rd_data[1], 64'd0);
        check("rst_rd_x31", rd_data[2], 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_ready", 64'(rsv_ready), 64'd1);
        run_cycle();

        // Write collision on x5: port 1 wins, bypassed and stored
        idle();
        wr_en      = 2'b11;
        wr_addr[0] = 5'd5;
        wr_addr[1] = 5'd5;
        wr_data[0] = 64'hdeadbeefdeadbeef;
        wr_data[1] = 64'hcafef00dcafef00d;
        rd_addr[0] = 5'd5;
        #1;
        check("bypass_x5", rd_data[0], 64'hcafef00dcafef00d);
        run_cycle();
        wr_en = '0;
        #1;
        check("stored_x5", rd_data[0], 64'hcafef00dcafef00d);
        run_cycle();

        // Write + release on x0 has no effect
        idle();
        wr_en      = 2'b01;
        wr_rel     = 2'b01;
        wr_addr[0] = 5'd0;
        wr_data[0] = '1;
        #1;
        check("x0_bypass", rd_data[0], 64'd0);
        run_cycle();
        idle();
        #1;
        check("x0_read", rd_data[0], 64'd0);
        check("x0_sb_err", 64'(sb_err), 64'd0);
        check("x0_pending", 64'(pending[0]), 64'd0);
        run_cycle();

        // Saturate x10, then release-while-reserve, then drain
        idle();
        rsv_valid = 1'b1;
        rsv_addr  = 5'd10;
        repeat (3) run_cycle();
        #1;
        check("x10_pending", 64'(pending[10]), 64'd1);
        check("x10_full", 64'(rsv_ready), 64'd0);
        run_cycle();
        wr_en      = 2'b01;
        wr_rel     = 2'b01;
        wr_addr[0] = 5'd10;
        #1;
        check("x10_ready_rel", 64'(rsv_ready), 64'd1);
        run_cycle();
        idle();
        rsv_addr = 5'd10;
        #1;
        check("x10_still_full", 64'(rsv_ready), 64'd0);
        run_cycle();
        wr_en      = 2'b01;
        wr_rel     = 2'b01;
        wr_addr[0] = 5'd10;
        repeat (3) run_cycle();
        idle();
        #1;
        check("x10_drained", 64'(pending[10]), 64'd0);
        check("x10_no_err", 64'(sb_err), 64'd0);
        run_cycle();

        // Double release of x7 with count 1 -> underflow, sticky error
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        run_cycle();
        idle();
        wr_en   = 2'b11;
        wr_rel  = 2'b11;
        wr_addr = {5'd7, 5'd7};
        run_cycle();
        idle();
        #1;
        check("x7_err", 64'(sb_err), 64'd1);
        check("x7_cleared", 64'(pending[7]), 64'd0);
        repeat (3) run_cycle();
        #1;
        check("x7_err_sticky", 64'(sb_err), 64'd1);

        // Flush beats a same-cycle reserve; data untouched
        wr_en   = 2'b11;
        wr_addr = {5'd4, 5'd3};
        wr_data = {64'h4444_0000_aaaa_5555, 64'h3333_1111_2222_9999};
        run_cycle();
        idle();
        rsv_valid = 1'b1;
        rsv_addr  = 5'd3;
        run_cycle();
        rsv_addr = 5'd4;
        run_cycle();
        rsv_addr = 5'd9;
        flush    = 1'b1;
        #1;
        check("pre_flush", 64'(pending[4:3]), 64'd3);
        run_cycle();
        idle();
        rd_addr = {5'd0, 5'd0, 5'd4, 5'd3};
        #1;
        check("flush_pending", 64'(pending), 64'd0);
        check("flush_x3", rd_data[0], 64'h3333_1111_2222_9999);
        check("flush_x4", rd_data[1], 64'h4444_0000_aaaa_5555);
        run_cycle();

        // Reset clears the sticky error
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        #1;
        check("rst_clears_err", 64'(sb_err), 64'd0);

        // Randomized traffic on a narrow address window to force collisions
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            rsv_valid = $urandom_range(0, 1) == 1;
            rsv_addr  = AW'($urandom_range(0, 7));
            for (int i = 0; i < NRD; i++) rd_addr[i] = AW'($urandom_range(0, 8));
            for (int p = 0; p < NWR; p++) begin
                wr_en[p]   = $urandom_range(0, 1) == 1;
                wr_rel[p]  = ($urandom_range(0, 3) == 0);
                wr_addr[p] = AW'($urandom_range(0, 7));
                wr_data[p] = {$urandom, $urandom};
            end
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
